memory_stage: RTL and testbench

- Memory (M) stage of the 64-bit in-order RISC-V pipeline, between execute and writeback.
- Takes one executed instruction per handshake and, for loads and stores, runs a data-bus transaction.
- Aligns load data and sign/zero-extends it.
- Registers the result (write address, write data, write enable) for the writeback stage, which consumes it without backpressure.

---
 rtl/memory_stage.sv | 183 ++++++++++++++++++
 tb/tb_memory_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage of the 64-bit in-order pipeline: passes ALU results through,
// runs one data-bus transaction per load/store and aligns/extends load data.
module memory_stage #(
    parameter int XLEN      = 64,
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NREG_BITS-1:0] in_wa,
    input  logic                 in_regwen,
    input  logic [XLEN-1:0]      in_result,
    input  logic                 in_memread,
    input  logic                 in_memwrite,
    input  logic [1:0]           in_msize,
    input  logic                 in_munsigned,
    input  logic [XLEN-1:0]      in_wdata,
    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [7:0]           dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_data_ok,
    input  logic [XLEN-1:0]      dresp_data,
    output logic                 out_valid,
    output logic [NREG_BITS-1:0] out_wa,
    output logic [XLEN-1:0]      out_wd,
    output logic                 out_regwen,
    output logic                 out_misalign
);

    // state  | meaning
    // S_IDLE | ready for a new instruction
    // S_BUSY | bus request outstanding, waiting for dresp_data_ok
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [XLEN-1:0]       r_addr;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [NREG_BITS-1:0]  r_wa;
    logic                  r_regwen;
    logic                  r_write;
    logic [XLEN-1:0]       r_wdata;

    logic                  r_out_valid;
    logic [NREG_BITS-1:0]  r_out_wa;
    logic [XLEN-1:0]       r_out_wd;
    logic                  r_out_regwen;
    logic                  r_out_misalign;

    logic                  w_accept;
    logic                  w_memop;
    logic [2:0]            w_size_mask;
    logic                  w_misalign;
    logic [5:0]            w_shamt;
    logic [7:0]            w_strobe_base;
    logic [XLEN-1:0]       w_ld_shift;
    logic [XLEN-1:0]       w_ld_ext;

    assign in_ready = (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_memop  = in_memread || in_memwrite;

    always_comb begin
        w_size_mask = 3'b000;
        case (in_msize)
            2'd0:    w_size_mask = 3'b000;
            2'd1:    w_size_mask = 3'b001;
            2'd2:    w_size_mask = 3'b011;
            default: w_size_mask = 3'b111;
        endcase
    end

    assign w_misalign = |(in_result[2:0] & w_size_mask);

    // Only the low three address bits select the byte lane.
    assign w_shamt = {r_addr[2:0], 3'b000};

    always_comb begin
        w_strobe_base = 8'h00;
        case (r_size)
            2'd0:    w_strobe_base = 8'h01;
            2'd1:    w_strobe_base = 8'h03;
            2'd2:    w_strobe_base = 8'h0F;
            default: w_strobe_base = 8'hFF;
        endcase
    end

    assign dreq_valid  = (r_state == S_BUSY);
    assign dreq_addr   = r_addr;
    assign dreq_size   = {1'b0, r_size};
    assign dreq_strobe = (dreq_valid && r_write) ? (w_strobe_base << r_addr[2:0]) : 8'h00;
    assign dreq_data   = r_wdata << w_shamt;

    always_comb begin
        w_ld_shift = dresp_data >> w_shamt;
        w_ld_ext   = w_ld_shift;
        case (r_size)
            2'd0: w_ld_ext = r_unsigned ? {{(XLEN-8){1'b0}}, w_ld_shift[7:0]}
                                        : {{(XLEN-8){w_ld_shift[7]}}, w_ld_shift[7:0]};
            2'd1: w_ld_ext = r_unsigned ? {{(XLEN-16){1'b0}}, w_ld_shift[15:0]}
                                        : {{(XLEN-16){w_ld_shift[15]}}, w_ld_shift[15:0]};
            2'd2: w_ld_ext = r_unsigned ? {{(XLEN-32){1'b0}}, w_ld_shift[31:0]}
                                        : {{(XLEN-32){w_ld_shift[31]}}, w_ld_shift[31:0]};
            default: w_ld_ext = w_ld_shift;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_memop && !w_misalign) w_state_nxt = S_BUSY;
            S_BUSY: if (dresp_data_ok) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr         <= '0;
            r_size         <= '0;
            r_unsigned     <= 1'b0;
            r_wa           <= '0;
            r_regwen       <= 1'b0;
            r_write        <= 1'b0;
            r_wdata        <= '0;
            r_out_valid    <= 1'b0;
            r_out_wa       <= '0;
            r_out_wd       <= '0;
            r_out_regwen   <= 1'b0;
            r_out_misalign <= 1'b0;
        end else begin
            r_out_valid    <= 1'b0;
            r_out_regwen   <= 1'b0;
            r_out_misalign <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (!w_memop) begin
                        r_out_valid  <= 1'b1;
                        r_out_wa     <= in_wa;
                        r_out_wd     <= in_result;
                        r_out_regwen <= in_regwen;
                    end else if (w_misalign) begin
                        r_out_valid    <= 1'b1;
                        r_out_wa       <= in_wa;
                        r_out_wd       <= in_result;
                        r_out_misalign <= 1'b1;
                    end else begin
                        r_addr     <= in_result;
                        r_size     <= in_msize;
                        r_unsigned <= in_munsigned;
                        r_wa       <= in_wa;
                        r_regwen   <= in_regwen;
                        r_write    <= in_memwrite;
                        r_wdata    <= in_wdata;
                    end
                end
            end else if (dresp_data_ok) begin
                // Stores report their address and never write the register file.
                r_out_valid  <= 1'b1;
                r_out_wa     <= r_wa;
                r_out_wd     <= r_write ? r_addr : w_ld_ext;
                r_out_regwen <= r_regwen && !r_write;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_wa       = r_out_wa;
    assign out_wd       = r_out_wd;
    assign out_regwen   = r_out_regwen;
    assign out_misalign = r_out_misalign;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: each instruction's outcome is predicted
// from byte-level arithmetic and compared at the falling clock edge.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_wa;
    logic        in_regwen;
    logic [63:0] in_result;
    logic        in_memread;
    logic        in_memwrite;
    logic [1:0]  in_msize;
    logic        in_munsigned;
    logic [63:0] in_wdata;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [4:0]  out_wa;
    logic [63:0] out_wd;
    logic        out_regwen;
    logic        out_misalign;

    int total = 0;
    int bad   = 0;

    memory_stage #(.XLEN(64), .NREG_BITS(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wa        (in_wa),
        .in_regwen    (in_regwen),
        .in_result    (in_result),
        .in_memread   (in_memread),
        .in_memwrite  (in_memwrite),
        .in_msize     (in_msize),
        .in_munsigned (in_munsigned),
        .in_wdata     (in_wdata),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_size    (dreq_size),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .out_valid    (out_valid),
        .out_wa       (out_wa),
        .out_wd       (out_wd),
        .out_regwen   (out_regwen),
        .out_misalign (out_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-oriented reference for a load result.
    function automatic logic [63:0] load_ext(logic [63:0] d, int off, int nb, bit uns);
        logic [63:0] v;
        logic [63:0] m;
        v = d >> (off * 8);
        if (nb == 8) return v;
        m = (64'd1 << (nb * 8)) - 64'd1;
        v = v & m;
        if (!uns && v[nb*8-1]) v = v | ~m;
        return v;
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [4:0] wa, input bit rw, input logic [63:0] res,
                         input logic [63:0] wd);
        in_valid     = 1'b1;
        in_memread   = rd;
        in_memwrite  = wr;
        in_msize     = sz;
        in_munsigned = uns;
        in_wa        = wa;
        in_regwen    = rw;
        in_result    = res;
        in_wdata     = wd;
    endtask

    // Starts and ends on a falling edge; lat = BUSY cycles up to and including data_ok.
    task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [4:0] wa, input bit rw, input logic [63:0] res,
                          input logic [63:0] wd, input logic [63:0] rdata, input int lat);
        int          nb;
        int          off;
        bit          mis;
        bit          mem;
        logic [7:0]  e_strb;
        logic [63:0] e_data;
        logic [63:0] bmask;
        nb  = 1 << sz;
        off = int'(res[2:0]);
        mem = rd || wr;
        mis = mem && ((off % nb) != 0);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        drive(rd, wr, sz, uns, wa, rw, res, wd);
        @(negedge clk);
        in_valid = 1'b0;
        if (mem && !mis) begin
            e_strb = 8'h00;
            e_data = 64'd0;
            bmask  = 64'd0;
            for (int i = 0; i < 8; i++) begin
                if (wr && i >= off && i < off + nb) begin
                    e_strb[i]       = 1'b1;
                    e_data[i*8 +: 8] = wd[(i-off)*8 +: 8];
                    bmask[i*8 +: 8]  = 8'hFF;
                end
            end
            for (int c = 0; c < lat; c++) begin
                chk("dreq_valid", {63'd0, dreq_valid}, 64'd1);
                chk("dreq_addr", dreq_addr, res);
                chk("dreq_size", {61'd0, dreq_size}, {62'd0, sz});
                chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, e_strb});
                chk("dreq_data", dreq_data & bmask, e_data);
                chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
                chk("out_valid_busy", {63'd0, out_valid}, 64'd0);
                if (c == lat - 1) begin
                    dresp_data_ok = 1'b1;
                    dresp_data    = rdata;
                end
                @(negedge clk);
                dresp_data_ok = 1'b0;
                dresp_data    = {$urandom, $urandom};
            end
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("out_wa", {59'd0, out_wa}, {59'd0, wa});
            chk("out_wd", out_wd, wr ? res : load_ext(rdata, off, nb, uns));
            chk("out_regwen", {63'd0, out_regwen}, {63'd0, (rw && rd)});
            chk("out_misalign", {63'd0, out_misalign}, 64'd0);
            chk("dreq_done", {63'd0, dreq_valid}, 64'd0);
        end else begin
            chk("dreq_none", {63'd0, dreq_valid}, 64'd0);
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("out_wa", {59'd0, out_wa}, {59'd0, wa});
            chk("out_wd", out_wd, res);
            chk("out_regwen", {63'd0, out_regwen}, {63'd0, (rw && !mem)});
            chk("out_misalign", {63'd0, out_misalign}, {63'd0, mis});
        end
    endtask

    // One cycle with nothing offered; a stray data_ok must be ignored.
    task automatic idle_cycle();
        dresp_data_ok = 1'($urandom_range(0, 1));
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        chk("idle_regwen", {63'd0, out_regwen}, 64'd0);
        chk("idle_dreq", {63'd0, dreq_valid}, 64'd0);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        reset         = 1'b0;
        in_valid      = 1'b0;
        in_wa         = '0;
        in_regwen     = 1'b0;
        in_result     = '0;
        in_memread    = 1'b0;
        in_memwrite   = 1'b0;
        in_msize      = '0;
        in_munsigned  = 1'b0;
        in_wdata      = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_regwen", {63'd0, out_regwen}, 64'd0);
        chk("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
        chk("rst_out_wa", {59'd0, out_wa}, 64'd0);
        chk("rst_out_wd", out_wd, 64'd0);
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
        reset = 1'b1;

        // add x5 = 0x1234, then an empty cycle
        run_op(0, 0, 2'd3, 0, 5'd5, 1, 64'h1234, 64'd0, 64'd0, 1);
        idle_cycle();

        // lb / lbu from byte 3 holding 0x80
        run_op(1, 0, 2'd0, 0, 5'd9, 1, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 3);
        chk("lb_value", out_wd, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1, 0, 2'd0, 1, 5'd9, 1, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 3);
        chk("lbu_value", out_wd, 64'h80);

        // sw to the upper word lane
        drive(0, 1, 2'd2, 0, 5'd1, 1, 64'h1004, 64'hDEAD_BEEF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sw_strobe", {56'd0, dreq_strobe}, 64'hF0);
        chk("sw_data_hi", {32'd0, dreq_data[63:32]}, 64'hDEAD_BEEF);
        chk("sw_size", {61'd0, dreq_size}, 64'd2);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("sw_valid", {63'd0, out_valid}, 64'd1);
        chk("sw_regwen", {63'd0, out_regwen}, 64'd0);

        // misaligned lw
        run_op(1, 0, 2'd2, 0, 5'd3, 1, 64'h1002, 64'd0, 64'd0, 1);

        // ld with zero-wait response while an ALU op waits on in_valid
        drive(1, 0, 2'd3, 0, 5'd4, 1, 64'h2000, 64'd0);
        @(negedge clk);
        drive(0, 0, 2'd0, 0, 5'd7, 1, 64'h55, 64'd0);
        chk("b2b_ready_busy", {63'd0, in_ready}, 64'd0);
        chk("b2b_dreq", {63'd0, dreq_valid}, 64'd1);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("b2b_ld_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_ld_wa", {59'd0, out_wa}, 64'd4);
        chk("b2b_ld_wd", out_wd, 64'h0123_4567_89AB_CDEF);
        chk("b2b_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_alu_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_alu_wa", {59'd0, out_wa}, 64'd7);
        chk("b2b_alu_wd", out_wd, 64'h55);
        idle_cycle();

        // reset while a store is on the bus
        drive(0, 1, 2'd3, 0, 5'd2, 1, 64'h3008, 64'hCAFE);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_dreq_before", {63'd0, dreq_valid}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_dreq_after", {63'd0, dreq_valid}, 64'd0);
        chk("mid_strobe_after", {56'd0, dreq_strobe}, 64'd0);
        chk("mid_ready_after", {63'd0, in_ready}, 64'd1);
        chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
        reset         = 1'b1;
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        chk("mid_late_ok", {63'd0, out_valid}, 64'd0);
        chk("mid_late_dreq", {63'd0, dreq_valid}, 64'd0);

        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [1:0]  sz;
            logic [63:0] addr;
            logic [63:0] amask;
            kind = $urandom_range(0, 9);
            sz   = 2'($urandom_range(0, 3));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                amask = (64'd1 << sz) - 64'd1;
                addr  = addr & ~amask;
            end
            run_op(kind >= 4 && kind < 7, kind >= 7, sz, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), addr,
                   {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
